// File: rtl/signal_conflict_monitor_pkg.sv
// Shared lamp encodings, monitor states and fault-cause bit positions for the
// signal conflict monitor and its helpers.
package traffic_pkg;

    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_OFF = 3'b000;

    localparam int NUM_APPR = 4;
    localparam int A_M1     = 0;
    localparam int A_M2     = 1;
    localparam int A_MT     = 2;
    localparam int A_S      = 3;

    localparam int CAUSE_ENC  = 0;
    localparam int CAUSE_CONF = 1;
    localparam int CAUSE_SEQ  = 2;

    typedef enum logic [1:0] {
        S_REC = 2'd0,
        S_RUN = 2'd1,
        S_FLT = 2'd2
    } mon_state_e;

    function automatic logic lt_is_valid(input logic [2:0] lt);
        return (lt == LT_GRN) || (lt == LT_YEL) || (lt == LT_RED);
    endfunction

    // Invalid codes are deliberately not "non-red": they are reported only as
    // encoding errors, never as right-of-way conflicts.
    function automatic logic lt_is_nonred(input logic [2:0] lt);
        return (lt == LT_GRN) || (lt == LT_YEL);
    endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Flags an out-of-order light change on one approach (green->red, yellow->green,
// red->yellow). Changes touching an invalid code are never flagged here.
module lamp_seq_checker
    import traffic_pkg::*;
(
    input  logic [2:0] prev_i,
    input  logic [2:0] curr_i,
    output logic       illegal_o
);

    always_comb begin
        illegal_o = 1'b0;
        if ((prev_i == LT_GRN) && (curr_i == LT_RED)) illegal_o = 1'b1;
        if ((prev_i == LT_YEL) && (curr_i == LT_GRN)) illegal_o = 1'b1;
        if ((prev_i == LT_RED) && (curr_i == LT_YEL)) illegal_o = 1'b1;
    end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety stage between the approach timer FSM and the lamp drivers: registers the
// lamps, latches persistent errors into a flashing-red fault. SEQ_CHECK_EN adds
// per-approach sequence checking.
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FAULT_CYCLES   = 2,
    parameter int FLASH_HALF     = 1,
    parameter int ALL_RED_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_M1_in,
    input  logic [2:0] light_M2_in,
    input  logic [2:0] light_MT_in,
    input  logic [2:0] light_S_in,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [3:0] fault_cause
);

    localparam logic [7:0] FC_LAST = 8'(FAULT_CYCLES - 1);
    localparam logic [7:0] FH_LAST = 8'(FLASH_HALF - 1);
    localparam logic [7:0] AR_LAST = 8'(ALL_RED_CYCLES - 1);

    logic [NUM_APPR-1:0][2:0] light_in;
    logic [NUM_APPR-1:0]      valid;
    logic [NUM_APPR-1:0]      nonred;
    logic                     enc_err;
    logic                     conf_err;
    logic                     seq_err;
    logic                     err;
    logic [3:0]               cause_now;
    logic                     trip;
    logic [7:0]               err_cnt_d;

    mon_state_e               state_q;
    logic [7:0]               rec_cnt_q;
    logic [7:0]               err_cnt_q;
    logic [7:0]               flash_cnt_q;
    logic                     phase_q;
    logic [NUM_APPR-1:0][2:0] lamp_q;
    logic                     fault_q;
    logic [3:0]               cause_q;

    assign light_in = {light_S_in, light_MT_in, light_M2_in, light_M1_in};

    always_comb begin
        valid  = '0;
        nonred = '0;
        for (int i = 0; i < NUM_APPR; i++) begin
            valid[i]  = lt_is_valid(light_in[i]);
            nonred[i] = lt_is_nonred(light_in[i]);
        end
    end

    assign enc_err  = ~&valid;
    // M1 may run alongside M2 or MT; every other non-red pairing is a conflict.
    assign conf_err = (nonred[A_M2] & nonred[A_MT]) |
                      (nonred[A_S]  & (nonred[A_M1] | nonred[A_M2] | nonred[A_MT]));

`ifdef SEQ_CHECK_EN
    logic [NUM_APPR-1:0][2:0] prev_q;
    logic [NUM_APPR-1:0]      seq_flag;

    for (genvar g = 0; g < NUM_APPR; g++) begin : g_seq
        lamp_seq_checker u_seq (
            .prev_i    (prev_q[g]),
            .curr_i    (light_in[g]),
            .illegal_o (seq_flag[g])
        );
    end

    assign seq_err = |seq_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= {NUM_APPR{LT_RED}};
        end else begin
            prev_q <= light_in;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    assign err = enc_err | conf_err | seq_err;

    always_comb begin
        cause_now             = 4'b0000;
        cause_now[CAUSE_ENC]  = enc_err;
        cause_now[CAUSE_CONF] = conf_err;
        cause_now[CAUSE_SEQ]  = seq_err;
    end

    // The FAULT_CYCLES-th consecutive error cycle is the one that latches the fault.
    assign trip      = err && (err_cnt_q == FC_LAST);
    assign err_cnt_d = err ? (err_cnt_q + 8'd1) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REC;
            rec_cnt_q   <= 8'd0;
            err_cnt_q   <= 8'd0;
            flash_cnt_q <= 8'd0;
            phase_q     <= 1'b0;
            lamp_q      <= {NUM_APPR{LT_RED}};
            fault_q     <= 1'b0;
            cause_q     <= 4'b0000;
        end else begin
            case (state_q)
                S_REC: begin
                    lamp_q <= {NUM_APPR{LT_RED}};
                    if (trip) begin
                        state_q     <= S_FLT;
                        fault_q     <= 1'b1;
                        cause_q     <= cause_q | cause_now;
                        err_cnt_q   <= 8'd0;
                        flash_cnt_q <= 8'd0;
                        phase_q     <= 1'b0;
                    end else begin
                        err_cnt_q <= err_cnt_d;
                        if (rec_cnt_q == AR_LAST) begin
                            state_q   <= S_RUN;
                            rec_cnt_q <= 8'd0;
                        end else begin
                            rec_cnt_q <= rec_cnt_q + 8'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (trip) begin
                        state_q     <= S_FLT;
                        fault_q     <= 1'b1;
                        cause_q     <= cause_q | cause_now;
                        err_cnt_q   <= 8'd0;
                        flash_cnt_q <= 8'd0;
                        phase_q     <= 1'b0;
                        lamp_q      <= {NUM_APPR{LT_RED}};
                    end else begin
                        err_cnt_q <= err_cnt_d;
                        lamp_q    <= light_in;
                    end
                end
                S_FLT: begin
                    err_cnt_q <= 8'd0;
                    // A clear only counts once the upstream inputs are clean again.
                    if (fault_clr && !err) begin
                        state_q   <= S_REC;
                        fault_q   <= 1'b0;
                        cause_q   <= 4'b0000;
                        rec_cnt_q <= 8'd0;
                        lamp_q    <= {NUM_APPR{LT_RED}};
                    end else if (flash_cnt_q == FH_LAST) begin
                        flash_cnt_q <= 8'd0;
                        phase_q     <= ~phase_q;
                        lamp_q      <= phase_q ? {NUM_APPR{LT_RED}} : {NUM_APPR{LT_OFF}};
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_REC;
                    lamp_q  <= {NUM_APPR{LT_RED}};
                end
            endcase
        end
    end

    assign lamp_M1     = lamp_q[A_M1];
    assign lamp_M2     = lamp_q[A_M2];
    assign lamp_MT     = lamp_q[A_MT];
    assign lamp_S      = lamp_q[A_S];
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed and randomized bench for signal_conflict_monitor against a behavioural
// model of the monitor's rules; honours SEQ_CHECK_EN when defined.
module tb_signal_conflict_monitor;
    import traffic_pkg::*;

    localparam int FAULT_CYCLES   = 2;
    localparam int FLASH_HALF     = 1;
    localparam int ALL_RED_CYCLES = 3;

    localparam logic [2:0] PH_M1 [6] = '{LT_GRN, LT_GRN, LT_GRN, LT_YEL, LT_RED, LT_RED};
    localparam logic [2:0] PH_M2 [6] = '{LT_GRN, LT_YEL, LT_RED, LT_RED, LT_RED, LT_RED};
    localparam logic [2:0] PH_MT [6] = '{LT_RED, LT_RED, LT_GRN, LT_YEL, LT_RED, LT_RED};
    localparam logic [2:0] PH_S  [6] = '{LT_RED, LT_RED, LT_RED, LT_RED, LT_GRN, LT_YEL};

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_m1, in_m2, in_mt, in_s;
    logic       fault_clr;
    logic [2:0] lamp_m1, lamp_m2, lamp_mt, lamp_s;
    logic       fault;
    logic [3:0] fault_cause;

    always #5 clk = ~clk;

    signal_conflict_monitor #(
        .FAULT_CYCLES   (FAULT_CYCLES),
        .FLASH_HALF     (FLASH_HALF),
        .ALL_RED_CYCLES (ALL_RED_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .light_M1_in (in_m1),
        .light_M2_in (in_m2),
        .light_MT_in (in_mt),
        .light_S_in  (in_s),
        .fault_clr   (fault_clr),
        .lamp_M1     (lamp_m1),
        .lamp_M2     (lamp_m2),
        .lamp_MT     (lamp_mt),
        .lamp_S      (lamp_s),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q[$];

    // ---------------- reference model ----------------
    int         m_mode;     // 0 recovery, 1 running, 2 fault
    int         m_rec_t;    // edges spent in recovery
    int         m_run_len;  // length of the current error run
    int         m_flt_t;    // edges since fault entry
    logic [3:0] m_cause;
    logic [2:0] m_lamp [4];
    logic [2:0] m_prev [4];

    function automatic int lt_pos(input logic [2:0] v);
        return (v == LT_GRN) ? 0 : ((v == LT_YEL) ? 1 : 2);
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_rec_t   = 0;
        m_run_len = 0;
        m_flt_t   = 0;
        m_cause   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m_lamp[i] = LT_RED;
            m_prev[i] = LT_RED;
        end
    endtask

    task automatic model_step();
        logic [2:0] cur [4];
        bit nr [4];
        bit enc, conf, seq, err;
        cur[0] = in_m1; cur[1] = in_m2; cur[2] = in_mt; cur[3] = in_s;
        enc = 0; conf = 0; seq = 0;
        for (int i = 0; i < 4; i++) begin
            if (!(cur[i] inside {LT_GRN, LT_YEL, LT_RED})) enc = 1;
            nr[i] = (cur[i] == LT_GRN) || (cur[i] == LT_YEL);
        end
        conf = (nr[1] && nr[2]) || (nr[3] && (nr[0] || nr[1] || nr[2]));
`ifdef SEQ_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            if ((m_prev[i] inside {LT_GRN, LT_YEL, LT_RED}) &&
                (cur[i] inside {LT_GRN, LT_YEL, LT_RED}) &&
                (lt_pos(cur[i]) != lt_pos(m_prev[i])) &&
                (lt_pos(cur[i]) != (lt_pos(m_prev[i]) + 1) % 3))
                seq = 1;
        end
`endif
        err = enc || conf || seq;
        if (m_mode != 2) begin
            m_run_len = err ? m_run_len + 1 : 0;
            if (m_run_len >= FAULT_CYCLES) begin
                m_mode    = 2;
                m_cause   = m_cause | {1'b0, seq, conf, enc};
                m_flt_t   = 0;
                m_run_len = 0;
                for (int i = 0; i < 4; i++) m_lamp[i] = LT_RED;
            end else if (m_mode == 0) begin
                m_rec_t++;
                for (int i = 0; i < 4; i++) m_lamp[i] = LT_RED;
                if (m_rec_t == ALL_RED_CYCLES) m_mode = 1;
            end else begin
                for (int i = 0; i < 4; i++) m_lamp[i] = cur[i];
            end
        end else begin
            if (fault_clr && !err) begin
                m_mode  = 0;
                m_rec_t = 0;
                m_cause = 4'b0000;
                for (int i = 0; i < 4; i++) m_lamp[i] = LT_RED;
            end else begin
                m_flt_t++;
                for (int i = 0; i < 4; i++)
                    m_lamp[i] = (((m_flt_t / FLASH_HALF) % 2) == 1) ? LT_OFF : LT_RED;
            end
        end
        for (int i = 0; i < 4; i++) m_prev[i] = cur[i];
        exp_q.push_back({m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], (m_mode == 2), m_cause});
    endtask

    // ---------------- checks ----------------
    task automatic check_val(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [16:0] exp;
        logic [16:0] obs;
        obs = {lamp_m1, lamp_m2, lamp_mt, lamp_s, fault, fault_cause};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check_val(tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_in(input logic [2:0] m1, input logic [2:0] m2,
                          input logic [2:0] mt, input logic [2:0] s);
        in_m1 = m1; in_m2 = m2; in_mt = mt; in_s = s;
    endtask

    task automatic set_phase(input int p);
        set_in(PH_M1[p], PH_M2[p], PH_MT[p], PH_S[p]);
    endtask

    task automatic tick(input string tag);
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        if (rst_n) check_model(tag);
    endtask

    task automatic pulse_clr(input string tag);
        fault_clr = 1'b1;
        tick(tag);
        fault_clr = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int p;
        rst_n     = 1'b0;
        fault_clr = 1'b0;
        set_in(LT_RED, LT_RED, LT_RED, LT_RED);
        model_reset();
        #12;
        check_val("reset_outputs", {lamp_m1, lamp_m2, lamp_mt, lamp_s, fault, fault_cause},
                  {LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset, then first input-following edge.
        for (int i = 0; i < ALL_RED_CYCLES; i++) tick("rec_after_reset");
        check_val("rec_lamp_m1_red", 17'(lamp_m1), 17'(LT_RED));
        set_in(LT_GRN, LT_RED, LT_RED, LT_RED);
        tick("first_run_edge");
        check_val("first_run_m1_green", 17'(lamp_m1), 17'(LT_GRN));

        // Legal six-phase cycle, three times.
        for (int r = 0; r < 3; r++)
            for (int ph = 0; ph < 6; ph++) begin
                set_phase(ph);
                tick("legal_cycle");
            end
        set_in(LT_RED, LT_RED, LT_RED, LT_RED);
        tick("legal_cycle_end");
        check_val("legal_no_fault", 17'(fault), 17'(0));

        // One-cycle M2/MT conflict glitch between phases 1 and 2.
        set_phase(0); tick("glitch_pre0");
        set_phase(1); tick("glitch_pre1");
        set_in(LT_GRN, LT_YEL, LT_GRN, LT_RED); tick("glitch_conflict");
        set_phase(2); tick("glitch_post");
        check_val("glitch_no_fault", 17'(fault), 17'(0));

        // Conflict held two cycles latches the fault.
        set_in(LT_GRN, LT_GRN, LT_GRN, LT_RED);
        tick("conf_hold1");
        tick("conf_hold2");
        check_val("conf_fault", 17'(fault), 17'(1));
        check_val("conf_cause", 17'(fault_cause), 17'(4'b0010));
        check_val("conf_flash_on", 17'(lamp_m1), 17'(LT_RED));
        tick("conf_flash1");
        check_val("conf_flash_off", 17'(lamp_s), 17'(LT_OFF));
        tick("conf_flash2");
        check_val("conf_flash_on2", 17'(lamp_mt), 17'(LT_RED));

        set_in(LT_RED, LT_RED, LT_RED, LT_RED);
        tick("conf_settle");
        pulse_clr("conf_clear");
        check_val("conf_cleared", {13'd0, fault, fault_cause}, 17'd0);
        for (int i = 0; i < ALL_RED_CYCLES; i++) tick("conf_rec");

        // Invalid S encoding, clear while still invalid, then valid clear.
        set_in(LT_RED, LT_RED, LT_RED, 3'b011);
        tick("enc_hold1");
        tick("enc_hold2");
        check_val("enc_cause", 17'(fault_cause), 17'(4'b0001));
        pulse_clr("enc_clr_ignored");
        check_val("enc_clr_ignored_fault", 17'(fault), 17'(1));
        set_in(LT_RED, LT_RED, LT_RED, LT_RED);
        pulse_clr("enc_clr_accepted");
        check_val("enc_clr_accepted", {13'd0, fault, fault_cause}, 17'd0);
        for (int i = 0; i < ALL_RED_CYCLES; i++) begin
            tick("enc_rec");
            check_val("enc_rec_red", 17'(lamp_s), 17'(LT_RED));
        end
        set_in(LT_GRN, LT_RED, LT_RED, LT_RED);
        tick("enc_run");
        check_val("enc_run_m1", 17'(lamp_m1), 17'(LT_GRN));

        // Out-of-order M1 changes: green->red, red->yellow.
        set_in(LT_RED, LT_RED, LT_RED, LT_RED); tick("seq_g2r");
        set_in(LT_YEL, LT_RED, LT_RED, LT_RED); tick("seq_r2y");
`ifdef SEQ_CHECK_EN
        check_val("seq_fault", 17'(fault), 17'(1));
        check_val("seq_cause", 17'(fault_cause), 17'(4'b0100));
`else
        check_val("seq_no_fault", 17'(fault), 17'(0));
        check_val("seq_lamp_follow", 17'(lamp_m1), 17'(LT_YEL));
`endif
        set_in(LT_RED, LT_RED, LT_RED, LT_RED); tick("seq_settle");
        pulse_clr("seq_clear");
        for (int i = 0; i < ALL_RED_CYCLES; i++) tick("seq_rec");

        // Mid-operation reset while faulted.
        set_in(LT_RED, LT_GRN, LT_GRN, LT_RED);
        tick("rst_conf1");
        tick("rst_conf2");
        tick("rst_flash");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_async", {lamp_m1, lamp_m2, lamp_mt, lamp_s, fault, fault_cause},
                  {LT_RED, LT_RED, LT_RED, LT_RED, 1'b0, 4'b0000});
        model_reset();
        exp_q.delete();
        set_in(LT_RED, LT_RED, LT_RED, LT_RED);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < ALL_RED_CYCLES; i++) tick("midrst_rec");
        set_in(LT_GRN, LT_RED, LT_RED, LT_RED);
        tick("midrst_run");
        check_val("midrst_run_m1", 17'(lamp_m1), 17'(LT_GRN));

        // Randomized traffic with occasional corruption and clear pulses.
        p = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 6) p = (p + 1) % 6;
            set_phase(p);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0:       in_m1 = 3'($urandom_range(0, 7));
                    1:       in_m2 = 3'($urandom_range(0, 7));
                    2:       in_mt = 3'($urandom_range(0, 7));
                    default: in_s  = 3'($urandom_range(0, 7));
                endcase
            end
            fault_clr = ($urandom_range(0, 5) == 0);
            tick("random");
        end
        fault_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
